falafel_lsu: RTL and testbench
==============================

Name: falafel_lsu

Overview:
- Load/store unit that is the responder for the allocator core's header request channel.
- Accepts one `header_data_req_t` at a time and executes its `req_lsu_op_e` operation (LOCK, UNLOCK, LOAD, UPDATE, ALLOC_INSERT, FREE_INSERT, DELETE).
- Converts each operation into 64-bit word transactions on a single-outstanding memory port.
- Returns one `header_data_rsp_t` per request.
- Sits between the free-list allocator FSM and the memory/cache interconnect.

Parameters:
- LOCK_ADDR, 64'h0, byte address of the global free-list lock word.
- NEXT_OFFSET, BLOCK_NEXT_ADDR_OFFSET (8), byte offset of the next_addr word within a block header.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_i  input  header_data_req_t  request: header_data {addr, size, next_addr}, val, lsu_op.
- req_ready_o  output  1  high only in IDLE; request accepted when req_i.val && req_ready_o.
- rsp_o  output  header_data_rsp_t  response: header_data plus val.
- rsp_ready_i  input  1  consumer accepts the response.
- mem_req_o  output  1  memory request valid.
- mem_gnt_i  input  1  memory grant.
- mem_we_o  output  1  1 = write, 0 = read.
- mem_addr_o  output  64  byte address, word-aligned.
- mem_wdata_o  output  64  write data.
- mem_rvalid_i  input  1  transaction completion; asserted for both reads and writes.
- mem_rdata_i  input  64  read data, valid with mem_rvalid_i.

Behaviour:
- Reset values: all outputs 0 except req_ready_o = 1. Internal state IDLE, word index 0.
- Reset asserted mid-operation drops mem_req_o in the same cycle. No response is produced for the aborted request.
- States: IDLE -> ISSUE -> WAIT -> (ISSUE for the next word | RESP) -> IDLE.
- IDLE: on accept, latch the whole request and go to ISSUE. req_ready_o falls the cycle after accept.
- Only one request is in flight; req_i is ignored outside IDLE.
- ISSUE: hold mem_req_o/we/addr/wdata stable until mem_gnt_i, then go to WAIT.
- WAIT: on mem_rvalid_i, capture rdata for reads. Advance the word index or go to RESP.
- Exactly one memory transaction is outstanding at any time.
- Word sequences per operation (A = latched addr):
  - LOCK: read LOCK_ADDR.
    - If rdata != 0, re-issue the read (spin; unbounded).
    - If rdata == 0, write 64'h1 to LOCK_ADDR, then RESP.
  - UNLOCK: write 0 to LOCK_ADDR.
  - LOAD: read A (size), then read A+NEXT_OFFSET (next_addr).
  - UPDATE: write size to A, then next_addr to A+NEXT_OFFSET.
  - FREE_INSERT: same two writes as UPDATE; creates a new free header.
  - ALLOC_INSERT: write size to A only; allocated header carries size only.
  - DELETE: write next_addr to A+NEXT_OFFSET only; unlinks the predecessor.
  - Any other lsu_op encoding: no memory access. Go straight to RESP with the request echoed.
- Address arithmetic is 64-bit unsigned, wrap-around permitted. No alignment check.
- RESP: rsp_o.val = 1, header_data held stable until rsp_ready_i. Return to IDLE the cycle after the handshake.
- Response contents:
  - LOAD returns {A, read size, read next}.
  - All other ops echo the latched request header_data.
- rsp_o.val and header_data are 0 outside RESP.
- Latency with zero-wait memory (gnt in the ISSUE cycle, rvalid the next cycle, rsp_ready_i high): 1 cycle accept + 2 cycles per word + 1 cycle RESP.
  - LOAD: 6 cycles from accept to rsp_o.val.
  - DELETE: 4 cycles.
- mem_rvalid_i outside WAIT is ignored.
- mem_gnt_i while mem_req_o is low is ignored.

Test Plan:
- LOAD, addr 0x1000, memory[0x1000]=0x40, memory[0x1008]=0x2000 -> reads at 0x1000 then 0x1008; rsp {0x1000, 0x40, 0x2000}, val=1.
- UPDATE, addr 0x3000, size 0x80, next 0x0 -> writes 0x80@0x3000, then 0x0@0x3008 in order; rsp echoes request.
- LOCK with lock word 1 for 3 reads, then 0 -> 4 reads at LOCK_ADDR, one write of 1; rsp only after the write's rvalid. UNLOCK -> single write of 0.
- ALLOC_INSERT, addr 0x5000, size 0x28 -> exactly one write, 0x28@0x5000. DELETE, addr 0x6000, next 0x7000 -> exactly one write, 0x7000@0x6008.
- Backpressure: gnt delayed 3 cycles with addr/wdata checked stable; rsp_ready_i low 5 cycles -> rsp_o held stable, req_ready_o stays 0; a second req_i.val in that window is not accepted.
- rst_ni pulsed low during the LOAD WAIT state -> mem_req_o=0 and rsp val=0 immediately; after release, req_ready_o=1 and a new UNLOCK completes normally.

Source files
------------

// File: rtl/falafel_lsu_if.sv
// Header-request channel and memory port of the falafel load/store unit.
// The slave modport is the LSU's view; the master modport is the view of
// the allocator plus memory environment that surrounds it.
// lsu_op encoding: 0 LOCK, 1 UNLOCK, 2 LOAD, 3 UPDATE, 4 ALLOC_INSERT,
// 5 FREE_INSERT, 6 DELETE, 7 unused (answered without memory traffic).
interface falafel_lsu_if;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next_addr;
    } header_data_t;

    typedef struct packed {
        header_data_t header_data;
        logic         val;
        logic [2:0]   lsu_op;
    } header_data_req_t;

    typedef struct packed {
        header_data_t header_data;
        logic         val;
    } header_data_rsp_t;

    header_data_req_t req_i;
    logic             req_ready_o;
    header_data_rsp_t rsp_o;
    logic             rsp_ready_i;

    logic             mem_req_o;
    logic             mem_gnt_i;
    logic             mem_we_o;
    logic [63:0]      mem_addr_o;
    logic [63:0]      mem_wdata_o;
    logic             mem_rvalid_i;
    logic [63:0]      mem_rdata_i;

    modport slave (
        input  req_i, rsp_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, rsp_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, rsp_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, rsp_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/falafel_lsu.sv
// falafel_lsu: turns one header operation at a time into a short sequence of
// 64-bit word transactions on a single-outstanding memory port and answers
// with one response. All outputs are registered and derived from the next
// state, so they line up with the state register.
module falafel_lsu #(
    parameter logic [63:0] LOCK_ADDR   = 64'h0,
    parameter logic [63:0] NEXT_OFFSET = 64'd8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    falafel_lsu_if.slave bus
);

    localparam logic [2:0] OP_LOCK         = 3'd0;
    localparam logic [2:0] OP_UNLOCK       = 3'd1;
    localparam logic [2:0] OP_LOAD         = 3'd2;
    localparam logic [2:0] OP_UPDATE       = 3'd3;
    localparam logic [2:0] OP_ALLOC_INSERT = 3'd4;
    localparam logic [2:0] OP_FREE_INSERT  = 3'd5;
    localparam logic [2:0] OP_DELETE       = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Number of word transactions an op needs (LOCK counts read + final write;
    // its spin re-reads do not advance the word index).
    function automatic logic [1:0] fn_words(input logic [2:0] op);
        case (op)
            OP_LOCK, OP_LOAD, OP_UPDATE, OP_FREE_INSERT: fn_words = 2'd2;
            OP_UNLOCK, OP_ALLOC_INSERT, OP_DELETE:       fn_words = 2'd1;
            default:                                     fn_words = 2'd0;
        endcase
    endfunction

    state_e      r_state, w_state_nxt;
    logic        r_idx, w_idx_nxt;

    logic [2:0]  r_op, w_op_nxt;
    logic [63:0] r_addr, w_addr_nxt;
    logic [63:0] r_size, w_size_nxt;
    logic [63:0] r_next, w_next_nxt;

    logic        w_mem_we;
    logic [63:0] w_mem_addr;
    logic [63:0] w_mem_wdata;

    logic        r_req_ready;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;
    logic        r_rsp_val;
    logic [63:0] r_rsp_addr;
    logic [63:0] r_rsp_size;
    logic [63:0] r_rsp_next;

    logic        w_accept;
    logic        w_word_done;
    logic        w_lock_spin;
    logic        w_last_word;

    assign w_accept    = (r_state == ST_IDLE) && bus.req_i.val;
    assign w_word_done = (r_state == ST_WAIT) && bus.mem_rvalid_i;
    // A busy lock word sends LOCK back to re-read the same word.
    assign w_lock_spin = (r_op == OP_LOCK) && (r_idx == 1'b0) && (bus.mem_rdata_i != 64'd0);
    assign w_last_word = r_idx || (fn_words(r_op) == 2'd1);

    // State register: sequence position and word index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_idx   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: accept, hold until grant, wait for completion, respond.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_i.val) begin
                    w_idx_nxt = 1'b0;
                    if (fn_words(bus.req_i.lsu_op) != 2'd0) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_gnt_i) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    if (w_lock_spin) begin
                        w_state_nxt = ST_ISSUE;
                        w_idx_nxt   = 1'b0;
                    end else if (w_last_word) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_idx_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 1'b0;
            end
        endcase
    end

    // Next value of the latched request; LOAD overwrites size/next with read data
    // so the response can be taken straight from these registers.
    always_comb begin
        w_op_nxt   = r_op;
        w_addr_nxt = r_addr;
        w_size_nxt = r_size;
        w_next_nxt = r_next;
        if (w_accept) begin
            w_op_nxt   = bus.req_i.lsu_op;
            w_addr_nxt = bus.req_i.header_data.addr;
            w_size_nxt = bus.req_i.header_data.size;
            w_next_nxt = bus.req_i.header_data.next_addr;
        end else if (w_word_done && (r_op == OP_LOAD)) begin
            if (r_idx) begin
                w_next_nxt = bus.mem_rdata_i;
            end else begin
                w_size_nxt = bus.mem_rdata_i;
            end
        end else begin
            w_op_nxt = r_op;
        end
    end

    // Request latch register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op   <= 3'd0;
            r_addr <= 64'd0;
            r_size <= 64'd0;
            r_next <= 64'd0;
        end else begin
            r_op   <= w_op_nxt;
            r_addr <= w_addr_nxt;
            r_size <= w_size_nxt;
            r_next <= w_next_nxt;
        end
    end

    // Output logic: the word transaction selected by op and word index.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = 64'd0;
        w_mem_wdata = 64'd0;
        case (w_op_nxt)
            OP_LOCK: begin
                w_mem_we    = w_idx_nxt;
                w_mem_addr  = LOCK_ADDR;
                w_mem_wdata = w_idx_nxt ? 64'd1 : 64'd0;
            end
            OP_UNLOCK: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = LOCK_ADDR;
                w_mem_wdata = 64'd0;
            end
            OP_LOAD: begin
                w_mem_we    = 1'b0;
                w_mem_addr  = w_idx_nxt ? (w_addr_nxt + NEXT_OFFSET) : w_addr_nxt;
                w_mem_wdata = 64'd0;
            end
            OP_UPDATE, OP_FREE_INSERT: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = w_idx_nxt ? (w_addr_nxt + NEXT_OFFSET) : w_addr_nxt;
                w_mem_wdata = w_idx_nxt ? w_next_nxt : w_size_nxt;
            end
            OP_ALLOC_INSERT: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = w_addr_nxt;
                w_mem_wdata = w_size_nxt;
            end
            OP_DELETE: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = w_addr_nxt + NEXT_OFFSET;
                w_mem_wdata = w_next_nxt;
            end
            default: begin
                w_mem_we    = 1'b0;
                w_mem_addr  = 64'd0;
                w_mem_wdata = 64'd0;
            end
        endcase
    end

    // Output register: everything is zero outside its owning state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 64'd0;
            r_mem_wdata <= 64'd0;
            r_rsp_val   <= 1'b0;
            r_rsp_addr  <= 64'd0;
            r_rsp_size  <= 64'd0;
            r_rsp_next  <= 64'd0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_mem_req   <= (w_state_nxt == ST_ISSUE);
            r_mem_we    <= (w_state_nxt == ST_ISSUE) ? w_mem_we    : 1'b0;
            r_mem_addr  <= (w_state_nxt == ST_ISSUE) ? w_mem_addr  : 64'd0;
            r_mem_wdata <= (w_state_nxt == ST_ISSUE) ? w_mem_wdata : 64'd0;
            r_rsp_val   <= (w_state_nxt == ST_RESP);
            r_rsp_addr  <= (w_state_nxt == ST_RESP) ? w_addr_nxt : 64'd0;
            r_rsp_size  <= (w_state_nxt == ST_RESP) ? w_size_nxt : 64'd0;
            r_rsp_next  <= (w_state_nxt == ST_RESP) ? w_next_nxt : 64'd0;
        end
    end

    assign bus.req_ready_o                 = r_req_ready;
    assign bus.mem_req_o                   = r_mem_req;
    assign bus.mem_we_o                    = r_mem_we;
    assign bus.mem_addr_o                  = r_mem_addr;
    assign bus.mem_wdata_o                 = r_mem_wdata;
    assign bus.rsp_o.val                   = r_rsp_val;
    assign bus.rsp_o.header_data.addr      = r_rsp_addr;
    assign bus.rsp_o.header_data.size      = r_rsp_size;
    assign bus.rsp_o.header_data.next_addr = r_rsp_next;

endmodule

// File: tb/tb_falafel_lsu.sv
// Bench for falafel_lsu: directed vector table, hand-written reset sequences
// and randomized requests, all checked against an operation-level model of
// the expected word transactions and responses.
module tb_falafel_lsu;

    localparam logic [2:0]  OP_LOCK = 3'd0, OP_UNLOCK = 3'd1, OP_LOAD = 3'd2, OP_UPDATE = 3'd3;
    localparam logic [2:0]  OP_ALLOC = 3'd4, OP_FREE = 3'd5, OP_DELETE = 3'd6, OP_BAD = 3'd7;
    localparam logic [63:0] LOCK_A = 64'h0;
    localparam logic [63:0] NOFF   = 64'd8;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } txn_t;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a, s, n;
        int          spins, gnt_dly, rsp_hold;
        logic [63:0] ea, es, en;
        string       name;
    } vec_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    falafel_lsu_if bus();
    falafel_lsu #(.LOCK_ADDR(LOCK_A), .NEXT_OFFSET(NOFF)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

    int checks   = 0;
    int failures = 0;

    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [63:0] mem [logic [63:0]];
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    int          lock_busy = 0;
    bit          noise     = 1'b0;
    vec_t        vecs[11];

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic [63:0] a, s, n, input int spins,
                                input int gd, input int rh, input logic [63:0] ea, es, en, input string nm);
        vec_t v;
        v.op = op; v.a = a; v.s = s; v.n = n; v.spins = spins; v.gnt_dly = gd; v.rsp_hold = rh;
        v.ea = ea; v.es = es; v.en = en; v.name = nm;
        return v;
    endfunction

    // Expected word transactions of one operation, straight from the op table.
    function automatic void build_exp(input logic [2:0] op, input logic [63:0] a, s, n, input int spins);
        exp_q.delete();
        case (op)
            OP_LOCK: begin
                for (int i = 0; i <= spins; i++) exp_q.push_back('{1'b0, LOCK_A, 64'd0});
                exp_q.push_back('{1'b1, LOCK_A, 64'd1});
            end
            OP_UNLOCK: exp_q.push_back('{1'b1, LOCK_A, 64'd0});
            OP_LOAD: begin
                exp_q.push_back('{1'b0, a, 64'd0});
                exp_q.push_back('{1'b0, a + NOFF, 64'd0});
            end
            OP_UPDATE, OP_FREE: begin
                exp_q.push_back('{1'b1, a, s});
                exp_q.push_back('{1'b1, a + NOFF, n});
            end
            OP_ALLOC:  exp_q.push_back('{1'b1, a, s});
            OP_DELETE: exp_q.push_back('{1'b1, a + NOFF, n});
            default: ;
        endcase
    endfunction

    // Memory responder: grants after gnt_delay cycles, completes rv_delay cycles later.
    initial begin : responder
        bit          holding, pend;
        int          hold_cnt, pend_wait;
        logic        h_we;
        logic [63:0] h_addr, h_wdata, pend_data;
        holding = 1'b0; pend = 1'b0; hold_cnt = 0; pend_wait = 0;
        h_we = 1'b0; h_addr = 64'd0; h_wdata = 64'd0; pend_data = 64'd0;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 64'd0;
        forever begin
            @(negedge clk_i);
            bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 64'd0;
            if (!rst_ni) begin
                holding = 1'b0; pend = 1'b0;
            end else begin
                if (pend) begin
                    if (pend_wait > 0) pend_wait--;
                    else begin
                        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = pend_data; pend = 1'b0;
                    end
                end else if (noise && bus.mem_req_o && $urandom_range(0, 2) == 0) begin
                    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = {$urandom, $urandom};
                end
                if (bus.mem_req_o) begin
                    if (!holding) begin
                        holding = 1'b1; hold_cnt = gnt_delay;
                        h_we = bus.mem_we_o; h_addr = bus.mem_addr_o; h_wdata = bus.mem_wdata_o;
                    end else begin
                        chk64("hold_we", 64'(bus.mem_we_o), 64'(h_we));
                        chk64("hold_addr", bus.mem_addr_o, h_addr);
                        chk64("hold_wdata", bus.mem_wdata_o, h_wdata);
                    end
                    if (hold_cnt == 0) begin
                        bus.mem_gnt_i = 1'b1; holding = 1'b0;
                        log_q.push_back('{h_we, h_addr, h_wdata});
                        if (h_we) begin
                            mem[h_addr] = h_wdata;
                            pend_data = noise ? {$urandom, $urandom} : 64'd0;
                        end else if (h_addr == LOCK_A && lock_busy > 0) begin
                            lock_busy--;
                            pend_data = noise ? ({$urandom, $urandom} | 64'd1) : 64'd1;
                        end else begin
                            pend_data = rd(h_addr);
                        end
                        pend = 1'b1; pend_wait = rv_delay;
                    end else begin
                        hold_cnt--;
                    end
                end else if (noise) begin
                    bus.mem_gnt_i = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // One request end to end: accept, optional response backpressure, compare.
    task automatic run_req(input vec_t v, input bit zw);
        int cyc;
        logic [63:0] ha, hs, hn;
        log_q.delete();
        build_exp(v.op, v.a, v.s, v.n, v.spins);
        lock_busy = v.spins; gnt_delay = v.gnt_dly;
        bus.rsp_ready_i = (v.rsp_hold == 0);
        cyc = 0;
        while (!bus.req_ready_o && cyc < 50) begin @(negedge clk_i); cyc++; end
        chk64({v.name, "/ready"}, 64'(bus.req_ready_o), 64'd1);
        bus.req_i.val = 1'b1; bus.req_i.lsu_op = v.op;
        bus.req_i.header_data.addr = v.a; bus.req_i.header_data.size = v.s;
        bus.req_i.header_data.next_addr = v.n;
        @(negedge clk_i);
        bus.req_i.val = 1'b0;
        bus.req_i.header_data.addr = {$urandom, $urandom};
        bus.req_i.header_data.size = {$urandom, $urandom};
        chk64({v.name, "/ready_fell"}, 64'(bus.req_ready_o), 64'd0);
        cyc = 1;
        while (!bus.rsp_o.val && cyc < 3000) begin @(negedge clk_i); cyc++; end
        chk64({v.name, "/rsp_val"}, 64'(bus.rsp_o.val), 64'd1);
        if (zw) chk64({v.name, "/latency"}, 64'(cyc + 1), 64'(2 + 2 * exp_q.size()));
        chk64({v.name, "/rsp_addr"}, bus.rsp_o.header_data.addr, v.ea);
        chk64({v.name, "/rsp_size"}, bus.rsp_o.header_data.size, v.es);
        chk64({v.name, "/rsp_next"}, bus.rsp_o.header_data.next_addr, v.en);
        ha = bus.rsp_o.header_data.addr; hs = bus.rsp_o.header_data.size;
        hn = bus.rsp_o.header_data.next_addr;
        for (int k = 0; k < v.rsp_hold; k++) begin
            bus.req_i.val = 1'b1; bus.req_i.lsu_op = OP_UNLOCK;
            @(negedge clk_i);
            chk64({v.name, "/hold_val"}, 64'(bus.rsp_o.val), 64'd1);
            chk64({v.name, "/hold_addr"}, bus.rsp_o.header_data.addr, ha);
            chk64({v.name, "/hold_size"}, bus.rsp_o.header_data.size, hs);
            chk64({v.name, "/hold_next"}, bus.rsp_o.header_data.next_addr, hn);
            chk64({v.name, "/hold_ready"}, 64'(bus.req_ready_o), 64'd0);
        end
        bus.req_i.val = 1'b0; bus.rsp_ready_i = 1'b1;
        @(negedge clk_i);
        chk64({v.name, "/rsp_dropped"}, 64'(bus.rsp_o.val), 64'd0);
        chk64({v.name, "/rsp_zero"}, bus.rsp_o.header_data.addr, 64'd0);
        chk64({v.name, "/back_idle"}, 64'(bus.req_ready_o), 64'd1);
        chk64({v.name, "/ntx"}, 64'(log_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < log_q.size()) begin
                chk64({v.name, "/tx_we"}, 64'(log_q[i].we), 64'(exp_q[i].we));
                chk64({v.name, "/tx_addr"}, log_q[i].addr, exp_q[i].addr);
                if (exp_q[i].we) chk64({v.name, "/tx_wdata"}, log_q[i].wdata, exp_q[i].wdata);
            end
        end
    endtask

    // Reset pulse while a LOAD is in its ISSUE (in_wait=0) or WAIT (in_wait=1) phase.
    task automatic reset_mid(input bit in_wait, input string nm);
        int cyc;
        bit hit;
        log_q.delete(); lock_busy = 0; bus.rsp_ready_i = 1'b1;
        gnt_delay = in_wait ? 0 : 8; rv_delay = in_wait ? 8 : 0;
        bus.req_i.val = 1'b1; bus.req_i.lsu_op = OP_LOAD; bus.req_i.header_data.addr = 64'h1000;
        @(negedge clk_i);
        bus.req_i.val = 1'b0;
        cyc = 0; hit = 1'b0;
        while (!hit && cyc < 20) begin
            hit = in_wait ? (log_q.size() == 1 && !bus.mem_req_o) : bus.mem_req_o;
            if (!hit) begin @(negedge clk_i); cyc++; end
        end
        chk64({nm, "/reached"}, 64'(hit), 64'd1);
        @(posedge clk_i); #2;
        rst_ni = 1'b0; #1;
        chk64({nm, "/mem_req"}, 64'(bus.mem_req_o), 64'd0);
        chk64({nm, "/rsp_val"}, 64'(bus.rsp_o.val), 64'd0);
        chk64({nm, "/ready"}, 64'(bus.req_ready_o), 64'd1);
        @(negedge clk_i); #1;
        rst_ni = 1'b1; gnt_delay = 0; rv_delay = 0;
        cyc = log_q.size();
        repeat (6) @(negedge clk_i);
        chk64({nm, "/no_rsp"}, 64'(bus.rsp_o.val), 64'd0);
        chk64({nm, "/no_traffic"}, 64'(log_q.size()), 64'(cyc));
        chk64({nm, "/idle"}, 64'(bus.req_ready_o), 64'd1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t v;
        bus.req_i = '0; bus.rsp_ready_i = 1'b1;
        mem[64'h1000] = 64'h40; mem[64'h1008] = 64'h2000;
        repeat (3) @(negedge clk_i);
        chk64("rst/req_ready", 64'(bus.req_ready_o), 64'd1);
        chk64("rst/mem_req", 64'(bus.mem_req_o), 64'd0);
        chk64("rst/mem_we", 64'(bus.mem_we_o), 64'd0);
        chk64("rst/mem_addr", bus.mem_addr_o, 64'd0);
        chk64("rst/mem_wdata", bus.mem_wdata_o, 64'd0);
        chk64("rst/rsp_val", 64'(bus.rsp_o.val), 64'd0);
        chk64("rst/rsp_size", bus.rsp_o.header_data.size, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        vecs[0]  = mk(OP_LOAD,   64'h1000, 64'h5a,   64'ha5,   0, 0, 0, 64'h1000, 64'h40, 64'h2000, "load");
        vecs[1]  = mk(OP_UPDATE, 64'h3000, 64'h80,   64'h0,    0, 0, 0, 64'h3000, 64'h80, 64'h0,    "update");
        vecs[2]  = mk(OP_LOCK,   64'h11,   64'h22,   64'h33,   3, 0, 0, 64'h11,   64'h22, 64'h33,   "lock");
        vecs[3]  = mk(OP_UNLOCK, 64'h44,   64'h55,   64'h66,   0, 0, 0, 64'h44,   64'h55, 64'h66,   "unlock");
        vecs[4]  = mk(OP_ALLOC,  64'h5000, 64'h28,   64'h77,   0, 0, 0, 64'h5000, 64'h28, 64'h77,   "alloc");
        vecs[5]  = mk(OP_DELETE, 64'h6000, 64'h99,   64'h7000, 0, 0, 0, 64'h6000, 64'h99, 64'h7000, "delete");
        vecs[6]  = mk(OP_FREE,   64'h8000, 64'h30,   64'h9000, 0, 0, 0, 64'h8000, 64'h30, 64'h9000, "free");
        vecs[7]  = mk(OP_BAD,    64'habc,  64'hdef,  64'h123,  0, 0, 0, 64'habc,  64'hdef, 64'h123, "badop");
        vecs[8]  = mk(OP_LOAD,   64'h3000, 64'h1,    64'h2,    0, 3, 5, 64'h3000, 64'h80, 64'h0,    "backpr");
        vecs[9]  = mk(OP_UPDATE, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h0, 0, 0, 0,
                      64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h0, "wrap");
        vecs[10] = mk(OP_LOAD,   64'h8000, 64'h0,    64'h0,    0, 0, 0, 64'h8000, 64'h30, 64'h9000, "reload");
        foreach (vecs[i]) run_req(vecs[i], vecs[i].gnt_dly == 0 && vecs[i].rsp_hold == 0);

        reset_mid(1'b0, "rst_issue");
        reset_mid(1'b1, "rst_wait");
        run_req(mk(OP_UNLOCK, 64'h1, 64'h2, 64'h3, 0, 0, 0, 64'h1, 64'h2, 64'h3, "post_rst"), 1'b1);

        noise = 1'b1;
        for (int it = 0; it < 40; it++) begin
            v.op = 3'($urandom_range(0, 7));
            v.a = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                              : 64'({$urandom_range(1, 8191), 3'b000});
            v.s = {$urandom, $urandom};
            v.n = (v.a == 64'hFFFF_FFFF_FFFF_FFF8) ? 64'd0 : {$urandom, $urandom};
            if (v.op == OP_LOCK && rd(LOCK_A) != 64'd0) v.op = OP_UNLOCK;
            v.spins = (v.op == OP_LOCK) ? $urandom_range(0, 3) : 0;
            v.gnt_dly = $urandom_range(0, 3);
            v.rsp_hold = $urandom_range(0, 2);
            rv_delay = $urandom_range(0, 2);
            v.ea = v.a;
            v.es = (v.op == OP_LOAD) ? rd(v.a) : v.s;
            v.en = (v.op == OP_LOAD) ? rd(v.a + NOFF) : v.n;
            v.name = $sformatf("rnd%0d_op%0d", it, v.op);
            run_req(v, 1'b0);
        end
        noise = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
